serial_parity_receiver: RTL
===========================

Name: serial_parity_receiver

Overview:
- Serial frame receiver that checks parity over the received bits. It is the receiving end of the team's XOR-based parity-generator transmit path.
- Frame format: start bit 0, N data bits LSB first, one parity bit, stop bit 1.
- Decodes the frame, recomputes parity by running XOR, and presents the word with error flags on a valid/ack handshake.

Parameters:
- N, 8, data bits per frame (1..16).
- CLK_PER_BIT, 16, clock cycles per bit period; even, >= 4. Counter width is clog2(CLK_PER_BIT).

Ports:
- clock  input  1  system clock, rising edge.
- reset_  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, synchronous to clock.
- data  output  N  last received data word.
- out_valid  output  1  data and flags valid, held until acknowledged.
- out_ack  input  1  consumer accepts the word.
- parity_err  output  1  parity mismatch on the presented word.
- frame_err  output  1  stop bit sampled as 0 on the presented word.
- overrun  output  1  an unacknowledged word was overwritten (sticky).

Behaviour:
- Reset (reset_=0, asynchronous):
  - state=IDLE.
  - data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0.
  - Bit counter, sample counter, shift register and parity accumulator cleared.
  - Reset mid-frame discards the partial frame.
- Clock/reset: one clock domain, asynchronous active-low reset reset_, clock port named clock.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rxd=0 sampled at edge t0 -> START; sample counter loaded for CLK_PER_BIT/2.
- START: at t0+CLK_PER_BIT/2 sample rxd.
  - rxd=0 -> DATA; parity accumulator p=0.
  - rxd=1 -> IDLE (glitch). No output, no flag change.
- DATA: sample every CLK_PER_BIT cycles.
  - Bit i is sampled at t0+CLK_PER_BIT/2+(i+1)*CLK_PER_BIT.
  - Shift bit into shift register LSB first; p ^= rxd.
  - After N bits -> PARITY.
- PARITY: sample one period later; p ^= rxd -> STOP.
- STOP: sample at t0+CLK_PER_BIT/2+(N+2)*CLK_PER_BIT (t0+168 at defaults). On that edge:
  - data <= shift register.
  - parity_err <= p (even parity: total XOR of data and parity bit must be 0).
  - frame_err <= ~rxd.
  - out_valid <= 1.
  - Next state: rxd=1 -> IDLE; rxd=0 -> BREAK.
- BREAK: remain until rxd=1, then IDLE. Prevents retriggering on a held-low line.
- Handshake:
  - out_valid, data and flags stay stable until an edge with out_valid=1 and out_ack=1.
  - That edge clears out_valid and overrun; data and error flags keep their values.
  - out_ack while out_valid=0 is ignored.
- Word completion (STOP edge) with out_valid=1 and out_ack=0: new word overwrites data and flags, out_valid stays 1, overrun <= 1.
- Word completion with out_valid=1 and out_ack=1 on the same edge: new word loaded, out_valid stays 1, overrun unchanged (not set).
- Reception continues independently of the handshake; there is no backpressure on rxd.
- Latency: out_valid rises on the STOP sampling edge, i.e. CLK_PER_BIT/2+(N+2)*CLK_PER_BIT cycles after t0.

Optional Feature:
- Macro: PARITY_ODD_EN.
- Defined: odd parity. parity_err <= ~p at STOP, i.e. an error when data plus parity bit contain an even number of ones.
- Undefined: even parity as described under Behaviour.
- All other timing and behaviour are identical in both builds.

Test Plan:
- Defaults, even parity. Frame 0xA5, parity 0, stop 1, out_ack held 0 -> out_valid=1 at t0+168, data=0xA5, parity_err=0, frame_err=0, overrun=0.
- Frame 0x01 with parity bit 0 -> data=0x01, parity_err=1, frame_err=0. With PARITY_ODD_EN, same frame -> parity_err=0.
- Frame 0x3C, parity 0, stop bit 0, rxd held low 40 cycles -> frame_err=1. FSM stays in BREAK with no new frame until rxd=1. The following valid frame 0x55 is received correctly.
- rxd low for 4 cycles, then high -> no out_valid, flags unchanged, FSM back in IDLE by t0+8.
- Two frames 0x11 then 0x22 back-to-back, no ack -> data=0x22, out_valid=1, overrun=1. out_ack=1 for one cycle -> out_valid=0, overrun=0.
- reset_ pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately. The next frame 0x81 yields data=0x81 with no errors.

Source files
------------

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver
// Receives frames of: start bit 0, N data bits LSB first, one parity bit, stop bit 1.
// The line is sampled mid-bit, and parity is accumulated with a running XOR.
// The decoded word and its error flags are presented on a valid/ack handshake.
// Build option: define PARITY_ODD_EN for odd parity. Even parity is the default.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle; waiting for a low level to mark a possible start bit
// START  | half a bit period later, confirms the start bit or rejects a glitch
// DATA   | samples N data bits, one per bit period
// PARITY | samples the parity bit into the accumulator
// STOP   | samples the stop bit and publishes the word with its flags
// BREAK  | stop bit was low; waits for the line to return high
module serial_parity_receiver #(
    parameter int N           = 8,
    parameter int CLK_PER_BIT = 16
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         rxd,
    output logic [N-1:0] data,
    output logic         out_valid,
    input  logic         out_ack,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] smp_cnt_q, smp_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]  shift_q,   shift_d;
    logic          par_q,     par_d;
    logic [N-1:0]  data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          perr_q,    perr_d;
    logic          ferr_q,    ferr_d;
    logic          ovr_q,     ovr_d;

    logic sample;
    logic word_done;
    logic perr_new;

    // The sample counter counts down to zero; zero marks the mid-bit sampling edge.
    assign sample = (smp_cnt_q == '0);

`ifdef PARITY_ODD_EN
    assign perr_new = ~par_q;
`else
    assign perr_new = par_q;
`endif

    // Next-state logic for frame decoding, the sample timer, and the output handshake.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        word_done = 1'b0;

        if (state_q != IDLE && state_q != BREAK) begin
            smp_cnt_d = smp_cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rxd) begin
                    state_d   = START;
                    smp_cnt_d = HALF_M1;
                end
            end
            START: begin
                if (sample) begin
                    if (!rxd) begin
                        state_d   = DATA;
                        smp_cnt_d = FULL_M1;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    for (int i = 0; i < N - 1; i++) begin
                        shift_d[i] = shift_q[i+1];
                    end
                    shift_d[N-1] = rxd;
                    par_d        = par_q ^ rxd;
                    smp_cnt_d    = FULL_M1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    par_d     = par_q ^ rxd;
                    smp_cnt_d = FULL_M1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    word_done = 1'b1;
                    state_d   = rxd ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completing word always wins. Overrun is set only when the old word was not taken on this edge.
        if (word_done) begin
            data_d  = shift_q;
            perr_d  = perr_new;
            ferr_d  = ~rxd;
            valid_d = 1'b1;
            if (valid_q && !out_ack) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, counters, and registered outputs; an asynchronous reset discards any partial frame.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data       = data_q;
    assign out_valid  = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
